// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM driving fetch/execute datapath controls.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR_Data,
  output logic        run,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        con_enable,
  output logic        manual_R15_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        BAout,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic [4:0]  alu_instruction
);
  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, FETCH2, EX_T3, EX_T4, EX_T5, HALTED} state_t;
  localparam logic [4:0] LDI = 5'b01001, ADDI = 5'b01100, JR = 5'b10100, JAL = 5'b10101, HALT = 5'b11011;
  state_t state_q, state_d;
  logic [4:0] op_q, op_d;
  logic t3, t4, t5, ld, ad, ari, jr, jal;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
    end
  end
  // Opcode is captured on the edge entering EX_T3 so execute outputs stay pure Moore.
  assign op_d = (state_q == FETCH2) ? IR_Data[31:27] : op_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH0;
      FETCH0:  state_d = stop ? HALTED : FETCH1;
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = EX_T3;
      EX_T3:   state_d = (ari || jal) ? EX_T4 : (op_q == HALT) ? HALTED : FETCH0;
      EX_T4:   state_d = ari ? EX_T5 : FETCH0;
      EX_T5:   state_d = FETCH0;
      default: state_d = HALTED;
    endcase
  end
  assign t3  = state_q == EX_T3;
  assign t4  = state_q == EX_T4;
  assign t5  = state_q == EX_T5;
  assign ld  = op_q == LDI;
  assign ad  = op_q == ADDI;
  assign ari = ld || ad;
  assign jr  = op_q == JR;
  assign jal = op_q == JAL;
  assign run                 = !(state_q == IDLE || state_q == HALTED);
  assign MAR_enable          = state_q == FETCH0;
  assign PC_select           = state_q == FETCH0 || (t3 && jal);
  assign PC_increment_enable = state_q == FETCH1;
  assign read                = state_q == FETCH1;
  assign MDR_enable          = state_q == FETCH1;
  assign MDR_select          = state_q == FETCH2;
  assign IR_enable           = state_q == FETCH2;
  assign Grb                 = t3 && ari;
  assign BAout               = t3 && ld;
  assign Y_enable            = t3 && ari;
  assign manual_R15_enable   = t3 && jal;
  assign r_select            = (t3 && (ad || jr)) || (t4 && jal);
  assign PC_enable           = (t3 && jr) || (t4 && jal);
  assign Gra                 = (t3 && jr) || (t4 && jal) || (t5 && ari);
  assign c_select            = t4 && ari;
  assign Z_enable            = t4 && ari;
  assign alu_instruction     = (t4 && ari) ? 5'b00001 : 5'b00000;
  assign Z_LO_select         = t5 && ari;
  assign r_enable            = t5 && ari;
  assign write               = 1'b0;
  assign con_enable          = 1'b0;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: vector table plus corner sequences, scoreboard-checked.
module tb_control_sequencer;
  logic clk = 0, reset = 1, stop = 0;
  logic [31:0] IR_Data = '0;
  logic run, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable;
  logic r_enable, con_enable, manual_R15_enable, read, write, Gra, Grb, BAout, PC_select;
  logic Z_LO_select, MDR_select, c_select, r_select;
  logic [4:0] alu_instruction;
  logic [25:0] obs;
  int tests = 0, fails = 0;
  control_sequencer dut (
    .clk(clk), .reset(reset), .stop(stop), .IR_Data(IR_Data), .run(run),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable), .IR_enable(IR_enable),
    .Y_enable(Y_enable), .Z_enable(Z_enable), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .r_enable(r_enable), .con_enable(con_enable), .manual_R15_enable(manual_R15_enable),
    .read(read), .write(write), .Gra(Gra), .Grb(Grb), .BAout(BAout), .PC_select(PC_select),
    .Z_LO_select(Z_LO_select), .MDR_select(MDR_select), .c_select(c_select), .r_select(r_select),
    .alu_instruction(alu_instruction)
  );
  always #5 clk = ~clk;
  assign obs = {run, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable,
                MDR_enable, r_enable, con_enable, manual_R15_enable, read, write, Gra, Grb, BAout,
                PC_select, Z_LO_select, MDR_select, c_select, r_select, alu_instruction};
  localparam logic [25:0] RUN = 26'd1 << 25, PCE = 26'd1 << 24, PCI = 26'd1 << 23, IRE = 26'd1 << 22;
  localparam logic [25:0] YE = 26'd1 << 21, ZE = 26'd1 << 20, MARE = 26'd1 << 19, MDRE = 26'd1 << 18;
  localparam logic [25:0] RE = 26'd1 << 17, R15 = 26'd1 << 15, RD = 26'd1 << 14, GRA = 26'd1 << 12;
  localparam logic [25:0] GRB = 26'd1 << 11, BAO = 26'd1 << 10, PCS = 26'd1 << 9, ZLO = 26'd1 << 8;
  localparam logic [25:0] MDRS = 26'd1 << 7, CS = 26'd1 << 6, RS = 26'd1 << 5, ADD = 26'd1;
  localparam logic [25:0] S_OFF = '0, S_F0 = RUN | PCS | MARE, S_F1 = RUN | PCI | RD | MDRE;
  localparam logic [25:0] S_F2 = RUN | MDRS | IRE, S_NOP = RUN, S_LDI3 = RUN | GRB | BAO | YE;
  localparam logic [25:0] S_ADDI3 = RUN | GRB | RS | YE, S_T4 = RUN | CS | ZE | ADD;
  localparam logic [25:0] S_T5 = RUN | ZLO | GRA | RE, S_JR3 = RUN | GRA | RS | PCE;
  localparam logic [25:0] S_JAL3 = RUN | PCS | R15, S_JAL4 = RUN | GRA | RS | PCE;
  localparam logic [4:0] LDI = 5'b01001, ADDI = 5'b01100, JR = 5'b10100, JAL = 5'b10101;
  localparam logic [4:0] HALT = 5'b11011, BAD = 5'b11111;
  typedef struct {logic r; logic s; logic [4:0] op; logic [25:0] e; string nm;} vec_t;
  vec_t tbl[$];
  logic [25:0] sb[$];
  task automatic add(input logic r, input logic s, input logic [4:0] op, input logic [25:0] e, input string nm);
    vec_t v;
    v.r = r; v.s = s; v.op = op; v.e = e; v.nm = nm;
    tbl.push_back(v);
  endtask
  // Inputs set here are sampled by the next edge; the popped word is the post-edge Moore output.
  task automatic step(input logic r, input logic s, input logic [4:0] op, input logic [25:0] e, input string nm);
    logic [25:0] want;
    reset = r; stop = s; IR_Data = {op, 27'h0000_5A5};
    sb.push_back(e);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    tests++;
    if (obs !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, obs, want);
    end
  endtask
  initial begin
    add(1, 0, LDI, S_OFF, "reset_idle");
    add(1, 0, LDI, S_OFF, "reset_hold");
    add(0, 0, LDI, S_F0, "ldi_f0");
    add(0, 0, LDI, S_F1, "ldi_f1");
    add(0, 0, LDI, S_F2, "ldi_f2");
    add(0, 0, LDI, S_LDI3, "ldi_t3");
    add(0, 0, LDI, S_T4, "ldi_t4");
    add(0, 0, LDI, S_T5, "ldi_t5");
    add(0, 0, ADDI, S_F0, "ldi_done");
    add(0, 0, ADDI, S_F1, "addi_f1");
    add(0, 0, ADDI, S_F2, "addi_f2");
    add(0, 0, ADDI, S_ADDI3, "addi_t3");
    add(0, 0, ADDI, S_T4, "addi_t4");
    add(0, 0, ADDI, S_T5, "addi_t5");
    add(0, 0, JR, S_F0, "addi_done");
    add(0, 0, JR, S_F1, "jr_f1");
    add(0, 0, JR, S_F2, "jr_f2");
    add(0, 0, JR, S_JR3, "jr_t3");
    add(0, 0, JAL, S_F0, "jr_done");
    add(0, 0, JAL, S_F1, "jal_f1");
    add(0, 0, JAL, S_F2, "jal_f2");
    add(0, 0, JAL, S_JAL3, "jal_t3");
    add(0, 0, JAL, S_JAL4, "jal_t4");
    add(0, 0, BAD, S_F0, "jal_done");
    add(0, 0, BAD, S_F1, "nop_f1");
    add(0, 1, BAD, S_F2, "stop_f1_ignored");
    add(0, 0, BAD, S_NOP, "nop_t3");
    add(0, 0, LDI, S_F0, "nop_done");
    add(0, 0, LDI, S_F1, "mid_f1");
    add(0, 0, LDI, S_F2, "mid_f2");
    add(0, 0, LDI, S_LDI3, "mid_t3");
    add(0, 0, BAD, S_T4, "mid_change_t4");
    add(0, 0, BAD, S_T5, "mid_change_t5");
    add(0, 0, BAD, S_F0, "mid_done");
    add(0, 0, BAD, S_F1, "next_nop_f1");
    add(0, 0, BAD, S_F2, "next_nop_f2");
    add(0, 0, BAD, S_NOP, "next_nop_t3");
    add(0, 0, LDI, S_F0, "next_nop_done");
    add(0, 1, LDI, S_OFF, "stop_f0_halts");
    add(0, 0, LDI, S_OFF, "stop_halt_stays");
    foreach (tbl[i]) step(tbl[i].r, tbl[i].s, tbl[i].op, tbl[i].e, tbl[i].nm);
    for (int i = 0; i < 20; i++) step(0, 1'($urandom), 5'($urandom), S_OFF, "halted_hold");
    step(1, 0, LDI, S_OFF, "halt_reset");
    step(0, 0, LDI, S_F0, "halt_release");
    step(0, 0, LDI, S_F1, "rst_f1");
    step(0, 0, LDI, S_F2, "rst_f2");
    step(0, 0, LDI, S_LDI3, "rst_t3");
    step(0, 0, LDI, S_T4, "rst_t4");
    step(1, 0, LDI, S_OFF, "rst_mid_t4");
    step(0, 0, HALT, S_F0, "rst_release");
    step(0, 0, HALT, S_F1, "halt_f1");
    step(0, 0, HALT, S_F2, "halt_f2");
    step(0, 0, HALT, S_NOP, "halt_t3");
    for (int i = 0; i < 20; i++) step(0, 1'(i), 5'($urandom), S_OFF, "halt_op_hold");
    step(1, 1, JR, S_OFF, "final_reset");
    step(0, 0, JR, S_F0, "final_f0");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
